// File: rtl/scheduler_if.sv
// Router/token-controller side of the spike scheduler: packet writes, slot advance/clear, spike vector out.
// master = upstream agents driving packets and pulses; slave = the scheduler.
interface scheduler_if #(
    parameter int NUM_AXONS = 256,
    parameter int NUM_TICKS = 16
);
    localparam int TW = $clog2(NUM_TICKS);
    localparam int AW = $clog2(NUM_AXONS);

    logic                 wen;
    logic [TW-1:0]        delay;
    logic [AW-1:0]        axon_id;
    logic                 set;
    logic                 clr;
    logic [NUM_AXONS-1:0] axon_spikes;
    logic                 error;

    modport master (
        output wen, delay, axon_id, set, clr,
        input  axon_spikes, error
    );

    modport slave (
        input  wen, delay, axon_id, set, clr,
        output axon_spikes, error
    );
endinterface

// File: rtl/scheduler.sv
// Circular tick-slot spike buffer; writes, set and clr all land in 1 cycle, output is combinational from state.
// No backpressure: a packet is accepted every cycle; one aimed at the live slot is dropped and flags error.
module scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int NUM_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    scheduler_if.slave sif
);
    localparam int TW = $clog2(NUM_TICKS);

    logic [NUM_AXONS-1:0] slot_q [NUM_TICKS];
    logic [NUM_AXONS-1:0] slot_d [NUM_TICKS];
    logic [TW-1:0]        read_ptr_q, read_ptr_d;
    logic                 error_q, error_d;
    logic [TW-1:0]        target;

    // Target is taken from the pre-edge pointer so a delay-0 packet lands in the slot a same-cycle set makes current.
    always_comb begin
        slot_d     = slot_q;
        read_ptr_d = read_ptr_q;
        error_d    = error_q;
        target     = read_ptr_q + TW'(1) + sif.delay;

        if (sif.clr) begin
            slot_d[read_ptr_q] = '0;
        end

        if (sif.wen) begin
            if (sif.delay == {TW{1'b1}}) begin
                error_d = 1'b1;
            end else begin
                slot_d[target][sif.axon_id] = 1'b1;
            end
        end

        if (sif.set) begin
            read_ptr_d = read_ptr_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_TICKS; t++) begin
                slot_q[t] <= '0;
            end
            read_ptr_q <= '0;
            error_q    <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            read_ptr_q <= read_ptr_d;
            error_q    <= error_d;
        end
    end

    assign sif.axon_spikes = slot_q[read_ptr_q];
    assign sif.error       = error_q;
endmodule
